matrix_result_streamer: RTL and testbench
=========================================

Name: matrix_result_streamer

Overview:
Drains the flat result vector of the systolic multiplier and emits its elements one at a time on a valid/ready stream, in row-major order. It is the reader for the multiplier's parallel result output.
- On the multiplier's one-cycle done pulse, it snapshots result_c into an internal buffer.
- It then serialises the M*P elements to a downstream consumer, which may be a BRAM writer or an output port.
- The multiplier is therefore free to start the next computation while the previous result drains.

Parameters:
- DATA_WIDTH, 8, width of one result element (matches the multiplier's truncated output element).
- M, 8, result rows.
- P, 8, result columns.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- done_in  input  1  one-cycle pulse from the multiplier; result_c is valid in the same cycle.
- result_c  input  M*P*DATA_WIDTH  flat result; element (i,j) at bits [(i*P+j)*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  stream element available.
- out_ready  input  1  consumer accepts the element.
- out_data  output  DATA_WIDTH  current element.
- out_last  output  1  high with the final element (index M*P-1).
- busy  output  1  high while a snapshot is being streamed.
- overrun  output  1  sticky flag: a done_in pulse was dropped.
- clear_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, element index=0.
  - out_valid=0, out_last=0, busy=0, overrun=0.
  - out_data=0; out_data is forced to 0 whenever out_valid=0.
  - Buffer contents are don't-care.
- States: IDLE and STREAM.
- IDLE:
  - done_in=1 captures result_c into the buffer, sets index=0 and moves to STREAM.
  - out_valid and busy go high in the next cycle, giving a 1-cycle latency from done_in to the first element.
- STREAM:
  - out_valid=1; out_data = buffer element[index]; out_last = (index==M*P-1); busy=1.
- Transfer occurs when out_valid && out_ready at a clock edge.
  - Non-final element: index increments.
  - Final element: go to IDLE, so out_valid and busy are 0 in the next cycle.
- Handshake rules:
  - out_valid never drops without a transfer.
  - out_data and out_last are stable while out_valid=1 && out_ready=0.
  - With out_ready held high, one element transfers per cycle and a full matrix takes exactly M*P cycles.
- Output values come only from the buffer. Changes on result_c after capture have no effect.
- done_in in STREAM, not coincident with the final transfer:
  - The pulse is ignored; buffer and index are unchanged.
  - overrun is set to 1 in the next cycle.
- done_in coincident with the final transfer (back-to-back):
  - The new result_c is captured, index=0, and the block stays in STREAM.
  - out_valid remains 1 with no bubble, and overrun is not set.
- done_in in IDLE with out_ready irrelevant: captured normally.
- overrun priority:
  - Stays 1 until clear_overrun=1 or rst.
  - If clear_overrun and a new overrun event occur in the same cycle, set wins.
- Reset mid-stream: the rst value applies in the next cycle and the remaining elements are discarded. A subsequent done_in restarts from element 0.
- Index counter width is max(1, $clog2(M*P)). It never exceeds M*P-1 and has no wrap-around beyond the final element.

Optional Feature:
MATRIX_STREAM_IDX_EN
- Defined: adds output ports out_row [max(1,$clog2(M))-1:0] and out_col [max(1,$clog2(P))-1:0].
  - These give the (i,j) coordinates of the current element.
  - They are valid and stable under the same rules as out_data, and are 0 when out_valid=0 and after reset.
  - They are maintained as separate row/col counters: col wraps P-1→0 and increments row. No divider is used.
- Undefined: the ports do not exist and the block has no coordinate counters.

Test Plan:
1. M=P=2, DATA_WIDTH=8, result_c=32'h04030201, done_in pulse, out_ready=1 → out_data 01,02,03,04 on 4 consecutive cycles starting 1 cycle after done_in. out_last=1 only with 04. busy=0 and out_valid=0 the cycle after.
2. Same stimulus, out_ready=0 for 3 cycles after out_valid rises → out_data holds 01 and out_valid stays 1. Then 01,02,03,04 are delivered with no skip or duplicate. Changing result_c to 32'hFFFFFFFF after capture does not alter the output.
3. done_in pulse while index=1 → overrun=1 next cycle, and the stream still outputs 02,03,04 from the original snapshot. A clear_overrun pulse then gives overrun=0.
4. done_in with result_c=32'h08070605 in the same cycle as the final (04) transfer → out_valid stays 1 and the next elements are 05,06,07,08. overrun stays 0.
5. rst asserted after 2 transfers → next cycle out_valid=0, busy=0, overrun=0, out_data=0. A new done_in with 32'h0D0C0B0A streams 0A first.
6. With MATRIX_STREAM_IDX_EN, M=P=2 → (out_row,out_col) = (0,0),(0,1),(1,0),(1,1) alongside elements 01..04, and (0,0) when idle.

Source files
------------

// File: rtl/matrix_result_streamer_if.sv
//------------------------------------------------------------------------------
// Module      : matrix_result_streamer_if
// Description : Capture-side and stream-side signals of matrix_result_streamer.
//               Optional coordinate outputs exist when MATRIX_STREAM_IDX_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface matrix_result_streamer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 8,
    parameter int P          = 8
);
    localparam int c_ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam int c_COL_W = (P > 1) ? $clog2(P) : 1;

    logic                      done_in;
    logic [M*P*DATA_WIDTH-1:0] result_c;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out_data;
    logic                      out_last;
    logic                      busy;
    logic                      overrun;
    logic                      clear_overrun;
`ifdef MATRIX_STREAM_IDX_EN
    logic [c_ROW_W-1:0]        out_row;
    logic [c_COL_W-1:0]        out_col;
`endif

    modport master (
        input  done_in, result_c, out_ready, clear_overrun,
`ifdef MATRIX_STREAM_IDX_EN
        output out_row, out_col,
`endif
        output out_valid, out_data, out_last, busy, overrun
    );

    modport slave (
        output done_in, result_c, out_ready, clear_overrun,
`ifdef MATRIX_STREAM_IDX_EN
        input  out_row, out_col,
`endif
        input  out_valid, out_data, out_last, busy, overrun
    );
endinterface

`default_nettype wire

// File: rtl/matrix_result_streamer.sv
//------------------------------------------------------------------------------
// Module      : matrix_result_streamer
// Description : Snapshots the multiplier's flat result on done_in and streams
//               its M*P elements row-major on a valid/ready port.
//               Optional macro MATRIX_STREAM_IDX_EN adds out_row/out_col.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module matrix_result_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 8,
    parameter int P          = 8
) (
    input  wire                          clk,
    input  wire                          rst,
    matrix_result_streamer_if.master     strm
);
    localparam int c_N     = M * P;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;

    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_N - 1);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_STREAM = 1'b1;

    logic [0:0]            r_state;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_overrun;
    logic [DATA_WIDTH-1:0] r_buf [c_N];

    logic w_valid;
    logic w_xfer;
    logic w_final;
    logic w_capture;

    assign w_valid   = (r_state == c_STREAM);
    assign w_xfer    = w_valid && strm.out_ready;
    assign w_final   = w_xfer && (r_idx == c_LAST);
    // A done pulse landing on the final transfer reloads without a bubble.
    assign w_capture = strm.done_in && (!w_valid || w_final);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (strm.done_in) begin
                        r_state <= c_STREAM;
                        r_idx   <= '0;
                    end
                end
                default: begin
                    if (w_final) begin
                        r_idx <= '0;
                        if (!strm.done_in)
                            r_state <= c_IDLE;
                    end else if (w_xfer) begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_overrun <= 1'b0;
        else if (w_valid && strm.done_in && !w_final)
            r_overrun <= 1'b1;
        else if (strm.clear_overrun)
            r_overrun <= 1'b0;
    end

    // Buffer needs no reset: it is only observed after a capture.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < c_N; k++)
                r_buf[k] <= strm.result_c[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign strm.out_valid = w_valid;
    assign strm.busy      = w_valid;
    assign strm.out_data  = w_valid ? r_buf[r_idx] : '0;
    assign strm.out_last  = w_valid && (r_idx == c_LAST);
    assign strm.overrun   = r_overrun;

`ifdef MATRIX_STREAM_IDX_EN
    localparam int c_ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam int c_COL_W = (P > 1) ? $clog2(P) : 1;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(P - 1);

    logic [c_ROW_W-1:0] r_row;
    logic [c_COL_W-1:0] r_col;

    // Coordinates track the linear index incrementally instead of dividing it.
    always_ff @(posedge clk) begin
        if (rst || w_capture || w_final) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_xfer) begin
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + c_ROW_W'(1);
            end else begin
                r_col <= r_col + c_COL_W'(1);
            end
        end
    end

    assign strm.out_row = w_valid ? r_row : '0;
    assign strm.out_col = w_valid ? r_col : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_matrix_result_streamer.sv
//------------------------------------------------------------------------------
// Module      : tb_matrix_result_streamer
// Description : Directed and random stimulus against a queue-based reference
//               model of the result streamer (M=P=2, DATA_WIDTH=8).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_matrix_result_streamer;
    localparam int DW  = 8;
    localparam int MM  = 2;
    localparam int PP  = 2;
    localparam int NEL = MM * PP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [DW-1:0] m_q [$];
    bit            m_ovr = 1'b0;

    always #5 clk = ~clk;

    matrix_result_streamer_if #(.DATA_WIDTH(DW), .M(MM), .P(PP)) bus ();

    matrix_result_streamer #(.DATA_WIDTH(DW), .M(MM), .P(PP)) dut (
        .clk  (clk),
        .rst  (rst),
        .strm (bus.master)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Check outputs against the model, drive the next inputs, advance the model.
    task automatic step(input bit d, input logic [31:0] r, input bit rdy,
                        input bit clr, input bit rs);
        bit was_busy;
        bit emptied;
        bit set_ovr;
        int pos;
        @(negedge clk);
        was_busy = (m_q.size() != 0);
        check_val("out_valid", {31'b0, bus.out_valid}, {31'b0, was_busy});
        check_val("busy",      {31'b0, bus.busy},      {31'b0, was_busy});
        check_val("out_data",  {24'b0, bus.out_data},  was_busy ? {24'b0, m_q[0]} : 32'h0);
        check_val("out_last",  {31'b0, bus.out_last},  {31'b0, (m_q.size() == 1)});
        check_val("overrun",   {31'b0, bus.overrun},   {31'b0, m_ovr});
`ifdef MATRIX_STREAM_IDX_EN
        pos = was_busy ? NEL - m_q.size() : 0;
        check_val("out_row", 32'(bus.out_row), 32'(pos / PP));
        check_val("out_col", 32'(bus.out_col), 32'(pos % PP));
`else
        pos = 0;
`endif
        bus.done_in       = d;
        bus.result_c      = r;
        bus.out_ready     = rdy;
        bus.clear_overrun = clr;
        rst               = rs;
        if (rs) begin
            m_q.delete();
            m_ovr = 1'b0;
        end else begin
            emptied = 1'b0;
            set_ovr = 1'b0;
            if (was_busy && rdy) begin
                void'(m_q.pop_front());
                emptied = (m_q.size() == 0);
            end
            if (d) begin
                if (!was_busy || emptied) begin
                    for (int k = 0; k < NEL; k++)
                        m_q.push_back(r[k*DW +: DW]);
                end else begin
                    set_ovr = 1'b1;
                end
            end
            if (set_ovr)
                m_ovr = 1'b1;
            else if (clr)
                m_ovr = 1'b0;
        end
    endtask

    initial begin
        bus.done_in       = 1'b0;
        bus.result_c      = '0;
        bus.out_ready     = 1'b0;
        bus.clear_overrun = 1'b0;
        rst               = 1'b1;
        repeat (2) @(posedge clk);

        // Plain drain with ready held high.
        step(1, 32'h04030201, 1, 0, 0);
        repeat (6) step(0, 32'h0, 1, 0, 0);
        // Stall for three cycles while result_c changes after capture.
        step(1, 32'h04030201, 0, 0, 0);
        repeat (3) step(0, 32'hFFFFFFFF, 0, 0, 0);
        repeat (5) step(0, 32'hFFFFFFFF, 1, 0, 0);
        // Dropped done while mid-stream, then clear.
        step(1, 32'h04030201, 1, 0, 0);
        step(0, 32'h0, 1, 0, 0);
        step(1, 32'hAABBCCDD, 1, 0, 0);
        repeat (4) step(0, 32'h0, 1, 0, 0);
        step(0, 32'h0, 1, 1, 0);
        step(0, 32'h0, 1, 0, 0);
        // Back-to-back capture on the final transfer.
        step(1, 32'h04030201, 1, 0, 0);
        repeat (3) step(0, 32'h0, 1, 0, 0);
        step(1, 32'h08070605, 1, 0, 0);
        repeat (5) step(0, 32'h0, 1, 0, 0);
        // Reset mid-stream, then restart.
        step(1, 32'h04030201, 1, 0, 0);
        repeat (2) step(0, 32'h0, 1, 0, 0);
        step(0, 32'h0, 1, 0, 1);
        step(0, 32'h0, 1, 0, 0);
        step(1, 32'h0D0C0B0A, 1, 0, 0);
        repeat (5) step(0, 32'h0, 1, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 5) == 0), $urandom,
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 149) == 0));
        end
        step(0, 32'h0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
